mem_shadow_checker: RTL
=======================

Name: mem_shadow_checker

Overview:
- Synthesizable, simulation- and emulation-usable successor to the team's memory formal property modules.
- Keeps a byte-granular shadow memory of one write port.
- Predicts data for NUM_RD_PORTS independent read ports with configurable read latency and read-first or write-first collision semantics.
- Compares the DUT's returned read data, then reports per-port mismatch pulses, saturating counters and a first-error capture record.
- Sits beside any single-write/multi-read RAM, connected passively to its ports.

Parameters:
- ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH locations.
- DATA_WIDTH, 32, data bits; must be a multiple of 8.
- BE_WIDTH, DATA_WIDTH/8, byte-enable bits.
- NUM_RD_PORTS, 2, number of read ports, 1..4.
- RD_LATENCY, 1, cycles from rd_en sample to rd_data valid, 1..4.
- RD_MODE, RD_FIRST, collision semantics (RD_FIRST or WR_FIRST, from package enum).
- CNT_WIDTH, 16, width of err_count and check_count.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  DUT write strobe.
- wr_addr  in  ADDR_WIDTH  DUT write address.
- wr_data  in  DATA_WIDTH  DUT write data.
- wr_be  in  BE_WIDTH  DUT byte enables.
- rd_en  in  NUM_RD_PORTS  per-port read strobe.
- rd_addr  in  NUM_RD_PORTS*ADDR_WIDTH  packed read addresses; port p at [p*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  in  NUM_RD_PORTS*DATA_WIDTH  packed DUT read data, valid RD_LATENCY cycles after rd_en.
- clr_err  in  1  synchronous clear of error state.
- err_valid  out  NUM_RD_PORTS  per-port mismatch pulse, one cycle.
- err_sticky  out  1  set on first mismatch; held until clr_err or reset.
- err_x_sticky  out  1  X/Z detected (optional feature); constant 0 when the feature is off.
- err_count  out  CNT_WIDTH  saturating count of mismatching port-checks.
- check_count  out  CNT_WIDTH  saturating count of performed port-checks.
- first_err_port  out  2  port of the first mismatch.
- first_err_addr  out  ADDR_WIDTH  address of the first mismatch.
- first_err_exp  out  DATA_WIDTH  expected data, invalid bytes zeroed.
- first_err_got  out  DATA_WIDTH  DUT data, invalid bytes zeroed.

Behaviour:
- Reset (asynchronous):
  - All byte-valid bits of the shadow cleared; shadow data contents not reset.
  - Pipeline valid bits cleared, so in-flight checks are discarded.
  - All outputs 0.
- Write:
  - When wr_en is 1, each byte i with wr_be[i]=1 updates shadow[wr_addr] byte i and sets its valid bit at the edge.
  - wr_en with wr_be=0 is a no-op.
- Read sample (cycle T, port p with rd_en[p]=1):
  - Capture addr, expected data and a byte-valid mask from the shadow.
  - RD_FIRST: expected data and mask are the pre-edge contents, even if wr_addr==rd_addr in T.
  - WR_FIRST: bytes enabled by a same-cycle write to the same address are replaced by wr_data and marked valid.
- Pipeline: the capture travels RD_LATENCY register stages, one per port, independent; back-to-back reads every cycle are supported.
- Compare (cycle T+RD_LATENCY):
  - If mask==0: no check, no count.
  - Otherwise check_count increments by 1 per checking port.
  - Mismatch = any valid byte differs; it sets err_valid[p] for exactly one cycle.
  - err_count increments by the number of mismatching ports in that cycle.
  - Both counters saturate at all-ones.
- First-error capture: loads only when err_sticky is 0 at the edge; simultaneous mismatches resolve to the lowest port index.
- clr_err:
  - Clears err_sticky, err_x_sticky, err_count, check_count and the first_err_* fields.
  - Does not clear shadow contents, valid bits or the pipeline.
  - A mismatch in the same cycle as clr_err is recorded after the clear: count=1, sticky=1, capture loaded.
- Address wrap: addresses are full-range (DEPTH = 2**ADDR_WIDTH), so none are out of range.

Optional Feature:
- Macro: MEM_SHADOW_CHK_XCHECK_EN.
- Defined:
  - Any X/Z on a valid byte of rd_data at compare counts as a mismatch.
  - It also sets err_x_sticky.
  - X/Z on wr_data bytes being written sets err_x_sticky at the write edge.
- Undefined: no X logic synthesized; err_x_sticky tied 0; X compares follow plain != semantics.

Decomposition:
- Package mem_shadow_chk_pkg holds:
  - rd_mode_e (RD_FIRST=0, WR_FIRST=1).
  - Struct chk_entry_t {valid, addr, exp, mask}, sized by package-level max widths.
  - MAX_RD_PORTS=4 and MAX_RD_LATENCY=4.
- Sub-module mem_shadow_chk_delay: a parametrised RD_LATENCY-stage valid/data delay line, one instance per read port, reset clears valid only.

Test Plan:
- Write 0xDEADBEEF, be=0xF, to addr 3; rd_en[0] addr 3 next cycle; DUT returns 0xDEADBEEF after 1 cycle -> check_count=1, err_count=0, err_valid=0.
- Write be=0x1 data 0x000000AA to unwritten addr 5; read returns 0x123456AA -> no error (only byte 0 valid). Read returns 0x000000AB -> err_valid[0]=1, first_err_addr=5, first_err_exp=0xAA, first_err_got=0xAB.
- Same-cycle write 0x11111111 and read of addr 2, which holds 0x22222222, with DUT returning 0x22222222:
  - RD_FIRST: no error.
  - WR_FIRST: err_valid=1, err_count=1.
- Both ports mismatch in one cycle (ports 0 and 1, addrs 7 and 9) -> err_valid=0b11, err_count=2, first_err_port=0, first_err_addr=7.
- RD_LATENCY=3, reads every cycle for 8 cycles on a written addr; rst_n asserted after cycle 4 -> no check after reset, counters 0, err_valid 0; a subsequent read of the same addr is unchecked (valid bits cleared).
- err_count preloaded to 0xFFFF by forcing 70000 mismatches -> holds 0xFFFF. clr_err asserted together with a mismatch -> err_count=1, err_sticky=1.

Source files
------------

// File: rtl/mem_shadow_chk_pkg.sv
// ---------------------------------------------------------------------------
// mem_shadow_chk_pkg
//
// Shared types and limits for the memory shadow checker.
//   rd_mode_e     - collision semantics between a read and a same-cycle write
//                   to the same address (RD_FIRST returns old data, WR_FIRST
//                   returns the newly written bytes).
//   chk_entry_t   - one in-flight read check: captured address, expected data
//                   and byte-valid mask. Fields are sized by the package
//                   maxima so a single type serves every parametrisation; the
//                   top only uses the low ADDR/DATA/BE bits.
//   MAX_*         - upper bounds on the checker's parameters.
// ---------------------------------------------------------------------------
package mem_shadow_chk_pkg;

    localparam int MAX_RD_PORTS   = 4;
    localparam int MAX_RD_LATENCY = 4;
    localparam int MAX_ADDR_WIDTH = 16;
    localparam int MAX_DATA_WIDTH = 128;
    localparam int MAX_BE_WIDTH   = MAX_DATA_WIDTH / 8;

    typedef enum logic {
        RD_FIRST = 1'b0,
        WR_FIRST = 1'b1
    } rd_mode_e;

    typedef struct packed {
        logic                      valid;
        logic [MAX_ADDR_WIDTH-1:0] addr;
        logic [MAX_DATA_WIDTH-1:0] exp;
        logic [MAX_BE_WIDTH-1:0]   mask;
    } chk_entry_t;

endpackage

// File: rtl/mem_shadow_chk_delay.sv
// ---------------------------------------------------------------------------
// mem_shadow_chk_delay
//
// LATENCY-stage valid/data delay line carrying one read port's check entry
// from the sample edge to the compare cycle. A new entry may enter every
// cycle. Reset clears only the valid bits, which is enough to discard any
// in-flight checks; the data stages are left unreset.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   in_valid    - entry present this cycle
//   in_data     - entry payload (WIDTH bits)
//   out_valid   - entry present after LATENCY edges
//   out_data    - payload after LATENCY edges
// ---------------------------------------------------------------------------
module mem_shadow_chk_delay
    import mem_shadow_chk_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int WIDTH   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [LATENCY-1:0] vld_q;
    logic [WIDTH-1:0]   dat_q [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_valid;
            for (int s = 1; s < LATENCY; s++) begin
                vld_q[s] <= vld_q[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        dat_q[0] <= in_data;
        for (int s = 1; s < LATENCY; s++) begin
            dat_q[s] <= dat_q[s-1];
        end
    end

    assign out_valid = vld_q[LATENCY-1];
    assign out_data  = dat_q[LATENCY-1];

endmodule

// File: rtl/mem_shadow_checker.sv
// ---------------------------------------------------------------------------
// mem_shadow_checker
//
// Passive checker that sits beside a single-write / multi-read RAM. It keeps
// a byte-granular shadow of everything written, predicts the data each read
// port should return RD_LATENCY cycles after its rd_en, and compares that
// prediction with the RAM's rd_data on the valid bytes only.
//
// Interface semantics: all RAM-side inputs are observed strobes with no
// backpressure. A write is wr_en=1 at a rising edge; a read is rd_en[p]=1 at
// a rising edge, and its data is expected on rd_data RD_LATENCY edges later.
//
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   wr_en/addr/data/be - RAM write port
//   rd_en, rd_addr, rd_data - packed per-port RAM read ports
//   clr_err         - synchronous clear of error state and counters
//   err_valid       - per-port one-cycle mismatch pulse
//   err_sticky      - set on first mismatch, held until clr_err/reset
//   err_x_sticky    - X/Z seen on checked or written bytes (optional feature)
//   err_count       - saturating count of mismatching port-checks
//   check_count     - saturating count of performed port-checks
//   first_err_*     - port, address, expected and returned data (invalid
//                     bytes zeroed) of the first mismatch
//
// Build option: define MEM_SHADOW_CHK_XCHECK_EN to treat X/Z on valid read
// bytes as a mismatch and to flag X/Z in err_x_sticky. Without it no X logic
// exists and err_x_sticky is tied low.
// ---------------------------------------------------------------------------
module mem_shadow_checker
    import mem_shadow_chk_pkg::*;
#(
    parameter int       ADDR_WIDTH   = 4,
    parameter int       DATA_WIDTH   = 32,
    parameter int       BE_WIDTH     = DATA_WIDTH / 8,
    parameter int       NUM_RD_PORTS = 2,
    parameter int       RD_LATENCY   = 1,
    parameter rd_mode_e RD_MODE      = RD_FIRST,
    parameter int       CNT_WIDTH    = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wr_en,
    input  logic [ADDR_WIDTH-1:0]              wr_addr,
    input  logic [DATA_WIDTH-1:0]              wr_data,
    input  logic [BE_WIDTH-1:0]                wr_be,
    input  logic [NUM_RD_PORTS-1:0]            rd_en,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
    input  logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data,
    input  logic                               clr_err,
    output logic [NUM_RD_PORTS-1:0]            err_valid,
    output logic                               err_sticky,
    output logic                               err_x_sticky,
    output logic [CNT_WIDTH-1:0]               err_count,
    output logic [CNT_WIDTH-1:0]               check_count,
    output logic [1:0]                         first_err_port,
    output logic [ADDR_WIDTH-1:0]              first_err_addr,
    output logic [DATA_WIDTH-1:0]              first_err_exp,
    output logic [DATA_WIDTH-1:0]              first_err_got
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // -----------------------------------------------------------------------
    // Shadow memory: data is never reset, only the per-byte valid bits are,
    // so bytes the RAM has never been written are excluded from compares.
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] shadow_mem [DEPTH];
    logic [BE_WIDTH-1:0]   shadow_vld [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (wr_be[i]) begin
                    shadow_mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < DEPTH; a++) begin
                shadow_vld[a] <= '0;
            end
        end else if (wr_en) begin
            shadow_vld[wr_addr] <= shadow_vld[wr_addr] | wr_be;
        end
    end

    // -----------------------------------------------------------------------
    // Per-port capture, delay and compare
    // -----------------------------------------------------------------------
    logic [NUM_RD_PORTS-1:0] chk_vec;
    logic [NUM_RD_PORTS-1:0] mis_vec;
    logic [ADDR_WIDTH-1:0]   port_addr [NUM_RD_PORTS];
    logic [DATA_WIDTH-1:0]   port_exp  [NUM_RD_PORTS];
    logic [DATA_WIDTH-1:0]   port_got  [NUM_RD_PORTS];
`ifdef MEM_SHADOW_CHK_XCHECK_EN
    logic [NUM_RD_PORTS-1:0] xbad_vec;
`endif

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] cap_exp;
        logic [BE_WIDTH-1:0]   cap_mask;
        chk_entry_t            cap_entry;
        chk_entry_t            out_entry;
        logic                  out_valid;
        logic [BE_WIDTH-1:0]   out_mask;
        logic [DATA_WIDTH-1:0] byte_mask;
        logic [DATA_WIDTH-1:0] got_m;
        logic [DATA_WIDTH-1:0] exp_m;
        logic                  unused_entry;

        assign ra = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

        // Expected data at the sample edge. In WR_FIRST mode a same-cycle
        // write to the same address forwards its enabled bytes.
        always_comb begin
            cap_exp  = shadow_mem[ra];
            cap_mask = shadow_vld[ra];
            if (RD_MODE == WR_FIRST && wr_en && (wr_addr == ra)) begin
                for (int i = 0; i < BE_WIDTH; i++) begin
                    if (wr_be[i]) begin
                        cap_exp[i*8 +: 8] = wr_data[i*8 +: 8];
                        cap_mask[i]       = 1'b1;
                    end
                end
            end
        end

        always_comb begin
            cap_entry                       = '0;
            cap_entry.valid                 = rd_en[p];
            cap_entry.addr[ADDR_WIDTH-1:0]  = ra;
            cap_entry.exp[DATA_WIDTH-1:0]   = cap_exp;
            cap_entry.mask[BE_WIDTH-1:0]    = cap_mask;
        end

        mem_shadow_chk_delay #(
            .LATENCY (RD_LATENCY),
            .WIDTH   ($bits(chk_entry_t))
        ) u_delay (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (rd_en[p]),
            .in_data   (cap_entry),
            .out_valid (out_valid),
            .out_data  (out_entry)
        );

        // Only the low bits of the max-sized entry are meaningful here.
        assign unused_entry = ^out_entry;

        assign out_mask = out_entry.mask[BE_WIDTH-1:0];

        always_comb begin
            byte_mask = '0;
            for (int i = 0; i < BE_WIDTH; i++) begin
                byte_mask[i*8 +: 8] = {8{out_mask[i]}};
            end
        end

        assign got_m = rd_data[p*DATA_WIDTH +: DATA_WIDTH] & byte_mask;
        assign exp_m = out_entry.exp[DATA_WIDTH-1:0] & byte_mask;

        // A capture with no valid bytes is not a check at all.
        assign chk_vec[p]   = out_valid && (out_mask != '0);
`ifdef MEM_SHADOW_CHK_XCHECK_EN
        assign xbad_vec[p]  = chk_vec[p] && $isunknown(got_m);
        assign mis_vec[p]   = chk_vec[p] && (xbad_vec[p] || (got_m != exp_m));
`else
        assign mis_vec[p]   = chk_vec[p] && (got_m != exp_m);
`endif
        assign port_addr[p] = out_entry.addr[ADDR_WIDTH-1:0];
        assign port_exp[p]  = exp_m;
        assign port_got[p]  = got_m;
    end

    // -----------------------------------------------------------------------
    // Aggregate across ports; descending scan leaves the lowest mismatching
    // port in the selected record.
    // -----------------------------------------------------------------------
    logic [2:0]            n_chk;
    logic [2:0]            n_mis;
    logic                  any_mis;
    logic [1:0]            sel_port;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_exp;
    logic [DATA_WIDTH-1:0] sel_got;

    always_comb begin
        n_chk    = '0;
        n_mis    = '0;
        sel_port = '0;
        sel_addr = '0;
        sel_exp  = '0;
        sel_got  = '0;
        for (int p = NUM_RD_PORTS - 1; p >= 0; p--) begin
            n_chk = n_chk + {2'b00, chk_vec[p]};
            n_mis = n_mis + {2'b00, mis_vec[p]};
            if (mis_vec[p]) begin
                sel_port = 2'(p);
                sel_addr = port_addr[p];
                sel_exp  = port_exp[p];
                sel_got  = port_got[p];
            end
        end
    end

    assign any_mis = |mis_vec;

    function automatic logic [CNT_WIDTH-1:0] sat_add(
        input logic [CNT_WIDTH-1:0] base,
        input logic [2:0]           inc
    );
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, base} + {{(CNT_WIDTH-2){1'b0}}, inc};
        return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
    endfunction

    // clr_err zeroes the base first, so an event in the same cycle lands on
    // the cleared state.
    logic [CNT_WIDTH-1:0] err_base;
    logic [CNT_WIDTH-1:0] chk_base;
    logic                 sticky_base;

    assign err_base    = clr_err ? {CNT_WIDTH{1'b0}} : err_count;
    assign chk_base    = clr_err ? {CNT_WIDTH{1'b0}} : check_count;
    assign sticky_base = clr_err ? 1'b0 : err_sticky;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid      <= '0;
            err_sticky     <= 1'b0;
            err_count      <= '0;
            check_count    <= '0;
            first_err_port <= '0;
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_got  <= '0;
        end else begin
            err_valid   <= mis_vec;
            err_count   <= sat_add(err_base, n_mis);
            check_count <= sat_add(chk_base, n_chk);
            err_sticky  <= sticky_base | any_mis;
            if (any_mis && !sticky_base) begin
                first_err_port <= sel_port;
                first_err_addr <= sel_addr;
                first_err_exp  <= sel_exp;
                first_err_got  <= sel_got;
            end else if (clr_err) begin
                first_err_port <= '0;
                first_err_addr <= '0;
                first_err_exp  <= '0;
                first_err_got  <= '0;
            end
        end
    end

`ifdef MEM_SHADOW_CHK_XCHECK_EN
    logic [DATA_WIDTH-1:0] wr_byte_mask;
    logic                  wr_x;
    logic                  x_event;

    always_comb begin
        wr_byte_mask = '0;
        for (int i = 0; i < BE_WIDTH; i++) begin
            wr_byte_mask[i*8 +: 8] = {8{wr_be[i]}};
        end
    end

    assign wr_x    = wr_en && $isunknown(wr_data & wr_byte_mask);
    assign x_event = wr_x || (|xbad_vec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_x_sticky <= 1'b0;
        end else begin
            err_x_sticky <= (clr_err ? 1'b0 : err_x_sticky) | x_event;
        end
    end
`else
    assign err_x_sticky = 1'b0;
`endif

endmodule
